// File: rtl/alu_seq.sv
// Clocked ALU for the EX stage: single-cycle logic/arith/shift ops plus
// iterative unsigned multiply and divide behind a Start/Busy/Done handshake.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             Start,
    input  logic [3:0]       Aluc,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Hi,
    output logic             Z,
    output logic             V,
    output logic             Busy,
    output logic             Done
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    state_t state, state_nxt;

    logic [SHW-1:0]   cnt;
    logic             op_mul;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] res_hi;
    logic             res_v;
    logic             multi;
    logic             accept;
    logic             finish;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] quo_step;

    assign sum  = X + Y;
    assign diff = X - Y;
    assign sh   = Y[SHW-1:0];

    assign multi = (Aluc == OP_MULU) || ((Aluc == OP_DIVU) && (|Y));

    always_comb begin
        res_r  = '0;
        res_hi = '0;
        res_v  = 1'b0;
        case (Aluc)
            OP_ADD: begin
                res_r = sum;
                res_v = (X[WIDTH-1] == Y[WIDTH-1]) &&
                        (sum[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                res_r = diff;
                res_v = (X[WIDTH-1] != Y[WIDTH-1]) &&
                        (diff[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND:  res_r = X & Y;
            OP_OR:   res_r = X | Y;
            OP_XOR:  res_r = X ^ Y;
            OP_NOR:  res_r = ~(X | Y);
            OP_SLT:  res_r = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            OP_SLTU: res_r = {{(WIDTH-1){1'b0}}, (X < Y)};
            OP_SLL:  res_r = X << sh;
            OP_SRL:  res_r = X >> sh;
            OP_SRA:  res_r = $unsigned($signed(X) >>> sh);
            OP_DIVU: begin
                // Only reached with Y==0; nonzero divisors iterate.
                res_r  = '1;
                res_hi = X;
                res_v  = 1'b1;
            end
            default: ;
        endcase
    end

    // acc/quo hold {high, low} of the product, or {remainder, quotient}.
    always_comb begin
        mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, opa} : '0);
        div_t   = {acc, quo[WIDTH-1]};
        div_ge  = div_t >= {1'b0, opa};
        div_sub = div_t[WIDTH-1:0] - opa;
        if (op_mul) begin
            acc_step = mul_sum[WIDTH:1];
            quo_step = {mul_sum[0], quo[WIDTH-1:1]};
        end else begin
            acc_step = div_ge ? div_sub : div_t[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    accept = 1'b1;
                    if (multi) state_nxt = ITER;
                end
            end
            ITER: begin
                if (cnt == CNT_LAST) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state  <= IDLE;
            cnt    <= '0;
            op_mul <= 1'b0;
            opa    <= '0;
            acc    <= '0;
            quo    <= '0;
            R      <= '0;
            Hi     <= '0;
            Z      <= 1'b0;
            V      <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state <= state_nxt;
            Done  <= 1'b0;
            if (accept && !multi) begin
                R    <= res_r;
                Hi   <= res_hi;
                Z    <= ~|res_r;
                V    <= res_v;
                Done <= 1'b1;
            end
            if (accept && multi) begin
                op_mul <= (Aluc == OP_MULU);
                opa    <= (Aluc == OP_MULU) ? X : Y;
                quo    <= (Aluc == OP_MULU) ? Y : X;
                acc    <= '0;
                cnt    <= '0;
            end
            if (state == ITER) begin
                acc <= acc_step;
                quo <= quo_step;
                cnt <= cnt + 1'b1;
            end
            if (finish) begin
                R    <= quo_step;
                Hi   <= acc_step;
                Z    <= ~|quo_step;
                V    <= op_mul ? (|acc_step) : 1'b0;
                Done <= 1'b1;
            end
        end
    end

    assign Busy = (state == ITER);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Clrn;
    logic        start32, z32, v32, busy32, done32;
    logic [3:0]  aluc32;
    logic [31:0] x32, y32, r32, hi32;
    logic        start8, z8, v8, busy8, done8;
    logic [3:0]  aluc8;
    logic [7:0]  x8, y8, r8, hi8;

    alu_seq #(.WIDTH(32)) u32 (
        .Clk(Clk), .Clrn(Clrn), .Start(start32), .Aluc(aluc32),
        .X(x32), .Y(y32), .R(r32), .Hi(hi32), .Z(z32), .V(v32),
        .Busy(busy32), .Done(done32)
    );

    alu_seq #(.WIDTH(8)) u8 (
        .Clk(Clk), .Clrn(Clrn), .Start(start8), .Aluc(aluc8),
        .X(x8), .Y(y8), .R(r8), .Hi(hi8), .Z(z8), .V(v8),
        .Busy(busy8), .Done(done8)
    );

    typedef struct {
        logic [31:0] r;
        logic [31:0] hi;
        logic        z;
        logic        v;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin : mon32
        exp_t e;
        if (done32 === 1'b1) begin
            if (q32.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u32_spurious_done actual=1 required=0");
            end else begin
                e = q32.pop_front();
                chk({e.name, "_r"}, r32, e.r);
                chk({e.name, "_hi"}, hi32, e.hi);
                chk({e.name, "_z"}, {31'b0, z32}, {31'b0, e.z});
                chk({e.name, "_v"}, {31'b0, v32}, {31'b0, e.v});
                chk({e.name, "_cyc"}, cyc, e.cyc);
            end
        end
    end

    always @(negedge Clk) begin : mon8
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL u8_spurious_done actual=1 required=0");
            end else begin
                e = q8.pop_front();
                chk({e.name, "_r"}, {24'b0, r8}, e.r);
                chk({e.name, "_hi"}, {24'b0, hi8}, e.hi);
                chk({e.name, "_z"}, {31'b0, z8}, {31'b0, e.z});
                chk({e.name, "_v"}, {31'b0, v8}, {31'b0, e.v});
                chk({e.name, "_cyc"}, cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic issue32(input string name, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [31:0] ehi,
                           input logic ev, input bit multi);
        exp_t e;
        e.r = er;
        e.hi = ehi;
        e.z = (er == 32'h0);
        e.v = ev;
        e.cyc = cyc + 1 + (multi ? 32 : 0);
        e.name = name;
        q32.push_back(e);
        start32 = 1'b1;
        aluc32 = op;
        x32 = a;
        y32 = b;
        step();
        start32 = 1'b0;
    endtask

    task automatic wait32(input string name, input int exp_busy,
                          input int pulse_at);
        int n = 0;
        int nb = 0;
        while (q32.size() != 0 && n < 200) begin
            if (busy32 === 1'b1) nb++;
            start32 = (n == pulse_at);
            aluc32 = 4'b0000;
            x32 = $urandom;
            y32 = $urandom;
            step();
            n++;
        end
        start32 = 1'b0;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=<200", name, n);
            q32.delete();
        end
        chk({name, "_busy"}, nb, exp_busy);
    endtask

    initial begin
        exp_t e;
        int n;
        int nb;
        Clrn = 1'b0;
        start32 = 1'b0; aluc32 = 4'h0; x32 = '0; y32 = '0;
        start8 = 1'b0; aluc8 = 4'h0; x8 = '0; y8 = '0;
        repeat (2) step();
        chk("rst_r", r32, 32'h0);
        chk("rst_hi", hi32, 32'h0);
        chk("rst_zvbd", {28'b0, z32, v32, busy32, done32}, 32'h0);
        chk("rst8_bd", {30'b0, busy8, done8}, 32'h0);
        Clrn = 1'b1;
        step();

        // Back-to-back legacy and logic ops, one result per cycle
        issue32("add", 4'b0000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0);
        issue32("sub", 4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hE1E1E1E1, 0, 0, 0);
        issue32("and", 4'b0010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 0, 0, 0);
        issue32("or",  4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0);
        issue32("xor", 4'b0100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0);
        issue32("nor", 4'b0101, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 0, 0, 0);
        wait32("legacy", 0, -1);

        issue32("add_ovf", 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 1, 0);
        issue32("sub_ovf", 4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 0, 1, 0);
        issue32("slt",  4'b0110, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 0, 0);
        issue32("sltu", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 0, 0);
        issue32("sra",  4'b1010, 32'h80000000, 32'hFFFFFF04, 32'hF8000000, 0, 0, 0);
        issue32("srl",  4'b1001, 32'h80000000, 32'hFFFFFF04, 32'h08000000, 0, 0, 0);
        issue32("sll",  4'b1000, 32'h00000001, 32'h0000001F, 32'h80000000, 0, 0, 0);
        issue32("sra0", 4'b1010, 32'h80000000, 32'hFFFFFF00, 32'h80000000, 0, 0, 0);
        issue32("rsvd", 4'b1011, 32'h12345678, 32'h9ABCDEF0, 32'h0, 0, 0, 0);
        issue32("rsvd_f", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 0);
        wait32("cmp_shift", 0, -1);

        // Multi-cycle ops; each next Start lands in the previous Done cycle
        issue32("mulu", 4'b1100, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 1, 1);
        wait32("mulu", 32, 5);
        issue32("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 32'd2, 0, 1);
        wait32("divu", 32, -1);
        issue32("divu0", 4'b1101, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1, 0);
        wait32("divu0", 0, -1);
        issue32("mulu_z", 4'b1100, 32'h0, 32'h5, 32'h0, 32'h0, 0, 1);
        wait32("mulu_z", 32, -1);

        // Reset mid-iteration aborts without a Done
        issue32("mulu_abort", 4'b1100, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 32'h2, 1, 1);
        repeat (10) step();
        q32.delete();
        Clrn = 1'b0;
        step();
        Clrn = 1'b1;
        chk("abort_busy", {31'b0, busy32}, 32'h0);
        chk("abort_done", {31'b0, done32}, 32'h0);
        chk("abort_r", r32, 32'h0);
        chk("abort_hi", hi32, 32'h0);
        repeat (40) step();

        // WIDTH=8 instance
        e.r = 32'h01; e.hi = 32'hFE; e.z = 1'b0; e.v = 1'b1;
        e.cyc = cyc + 1 + 8; e.name = "mulu8";
        q8.push_back(e);
        start8 = 1'b1; aluc8 = 4'b1100; x8 = 8'hFF; y8 = 8'hFF;
        step();
        start8 = 1'b0;
        n = 0;
        nb = 0;
        while (q8.size() != 0 && n < 100) begin
            if (busy8 === 1'b1) nb++;
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL mulu8_timeout actual=%0d required=<100", n);
            q8.delete();
        end
        chk("mulu8_busy", nb, 8);

        repeat (5) step();
        chk("q_drained", q32.size() + q8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the CPU's combinational 2-bit-opcode ALU.
- Operand width is set by a parameter and the opcode widens to 4 bits. The four existing codes keep their meaning.
- Adds logic, compare, shift, iterative unsigned multiply and iterative unsigned divide.
- Start/Busy/Done handshake; results are registered. Sits in the EX stage and stalls the pipeline on Busy.

Parameters:
- WIDTH, 32: operand/result width. Power of two, >= 4.
- SHW, log2(WIDTH): shift-amount width. Derived localparam, not overridable.

Ports:
- Clk  in  1  rising-edge clock.
- Clrn  in  1  synchronous active-low reset.
- Start  in  1  request. Sampled only when Busy=0.
- Aluc  in  4  opcode. Sampled with Start.
- X  in  WIDTH  operand A. Latched on an accepted Start.
- Y  in  WIDTH  operand B. Latched on an accepted Start.
- R  out  WIDTH  result (low word / quotient).
- Hi  out  WIDTH  MULU high word / DIVU remainder. 0 for all other ops.
- Z  out  1  ~|R of the registered result.
- V  out  1  overflow / error flag.
- Busy  out  1  multi-cycle op in progress.
- Done  out  1  one-cycle pulse when R/Hi/Z/V update.

Behaviour:
- Reset: on a Clk edge with Clrn=0, state goes to IDLE and R, Hi, Z, V, Busy, Done and the counter all go to 0. Reset aborts any operation in flight and no Done is produced for it.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR (same as the legacy codes).
  - 0100 XOR, 0101 NOR.
  - 0110 SLT (signed), 0111 SLTU. Result is 1 or 0 in bit 0.
  - 1000 SLL, 1001 SRL, 1010 SRA. Shift amount is Y[SHW-1:0] and Y's upper bits are ignored.
  - 1100 MULU, 1101 DIVU.
  - 1011, 1110, 1111 reserved: R=0, Hi=0, V=0, one-cycle latency.
- V flag:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from X.
  - MULU: 1 iff Hi != 0.
  - DIVU: 1 iff divide by zero.
  - 0 for all other ops.
- Z is always ~|R, including for MULU and DIVU.
- States are IDLE and ITER. A WIDTH-cycle iteration counter spans 0..WIDTH-1.
- Single-cycle ops:
  - Start=1 in IDLE at edge k: outputs are registered at edge k and Done=1 during cycle k+1. State stays IDLE.
  - Back-to-back Start every cycle yields one result per cycle.
- DIVU with Y=0: single-cycle, R=all ones, Hi=X, V=1.
- MULU / DIVU (Y!=0):
  - Accepted Start at edge k latches X and Y, clears the counter and enters ITER. Busy=1 during cycles k+1 .. k+WIDTH.
  - One iteration per cycle:
    - MULU: shift-add, LSB of the multiplier first.
    - DIVU: restoring, MSB of the dividend first.
  - The final iteration writes R/Hi/Z/V at edge k+WIDTH. Busy falls and Done=1 during cycle k+WIDTH+1, state back in IDLE.
- Result timing: multi-cycle latency is WIDTH+1 edges from Start to Done. Single-cycle latency is 1 edge.
- Output hold: R, Hi, Z and V hold their value until the next result is written, so intermediate iteration values never appear on R/Hi.
- Start while Busy=1 is ignored with no queueing. Aluc, X and Y may change freely during ITER.
- Start asserted in the Done cycle (IDLE) is accepted normally.
- Arithmetic is modulo 2^WIDTH. MULU produces the full 2*WIDTH product in {Hi,R}.
- SRA replicates X[WIDTH-1]. A shift by 0 returns X.

Test Plan:
1. Legacy codes, WIDTH=32, X=F0F0F0F0, Y=0F0F0F0F.
   - ADD -> R=FFFFFFFF, V=0.
   - SUB -> R=E1E1E1E1, V=0.
   - AND -> R=0, Z=1.
   - OR -> R=FFFFFFFF.
   - Each has Done one cycle after Start.
2. Overflow and compare.
   - ADD 7FFFFFFF+1 -> R=80000000, V=1.
   - SUB 80000000-1 -> R=7FFFFFFF, V=1.
   - SLT X=FFFFFFFF, Y=1 -> R=1.
   - SLTU with the same operands -> R=0.
3. Shifts.
   - SRA X=80000000, Y=FFFFFF04 -> R=F8000000.
   - SRL with the same operands -> R=08000000.
   - SLL X=1, Y=1F -> R=80000000.
4. MULU X=FFFFFFFF, Y=2.
   - Busy high exactly 32 cycles, Done in cycle 33: R=FFFFFFFE, Hi=1, V=1.
   - A Start pulsed mid-ITER is ignored: no extra Done, result unchanged.
5. DIVU.
   - X=64 (100), Y=7 -> 33 cycles, R=E (14), Hi=2.
   - Y=0 -> 1 cycle, R=FFFFFFFF, Hi=64, V=1.
6. Reset and re-parametrisation.
   - Clrn=0 at iteration 10 of MULU -> next cycle Busy=0, Done=0, R=Hi=0.
   - Restart at WIDTH=8: MULU FF*FF -> Done in cycle 9, R=01, Hi=FE.
